// File: rtl/serial_magnitude_comparator.sv
// Bit-serial unsigned magnitude comparator: walks the operands MSB first through a 1-bit stage.
// Optional macro SERIAL_CMP_EARLY_EXIT_EN ends the sweep on the first unequal bit.
module serial_magnitude_comparator #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic             eq,
  output logic             gt,
  output logic             lt
);

  localparam int IDX_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_RUN  = 2'd1,
    S_DONE = 2'd2
  } state_t;

  state_t           state_q;
  logic [IDX_W-1:0] idx_q;
  logic [WIDTH-1:0] a_q, b_q;
  logic             decided_q, dec_gt_q;
  logic             busy_q, done_q, eq_q, gt_q, lt_q;

  logic             bit_a, bit_b;
  logic             decided_d, dec_gt_d, finish_d;

  // NOTE: every signal gets a default at the top of always_comb, so no path can infer a latch.
  always_comb begin
    bit_a     = a_q[idx_q];
    bit_b     = b_q[idx_q];
    // The first unequal bit wins; later bits never override a recorded decision.
    decided_d = decided_q | (bit_a ^ bit_b);
    dec_gt_d  = decided_q ? dec_gt_q : (bit_a & ~bit_b);
`ifdef SERIAL_CMP_EARLY_EXIT_EN
    finish_d  = (idx_q == '0) | (bit_a ^ bit_b);
`else
    finish_d  = (idx_q == '0);
`endif
  end

  // NOTE: sequential state uses non-blocking assignments only, so every register samples pre-edge values.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      idx_q     <= '0;
      a_q       <= '0;
      b_q       <= '0;
      decided_q <= 1'b0;
      dec_gt_q  <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      eq_q      <= 1'b0;
      gt_q      <= 1'b0;
      lt_q      <= 1'b0;
    end else begin
      done_q <= 1'b0;
      unique case (state_q)
        S_IDLE: begin
          if (start) begin
            a_q       <= a;
            b_q       <= b;
            idx_q     <= IDX_W'(WIDTH - 1);
            decided_q <= 1'b0;
            dec_gt_q  <= 1'b0;
            eq_q      <= 1'b0;
            gt_q      <= 1'b0;
            lt_q      <= 1'b0;
            busy_q    <= 1'b1;
            state_q   <= S_RUN;
          end
        end
        S_RUN: begin
          decided_q <= decided_d;
          dec_gt_q  <= dec_gt_d;
          if (finish_d) begin
            state_q <= S_DONE;
            busy_q  <= 1'b0;
            done_q  <= 1'b1;
            eq_q    <= ~decided_d;
            gt_q    <= decided_d & dec_gt_d;
            lt_q    <= decided_d & ~dec_gt_d;
          end else begin
            idx_q <= idx_q - IDX_W'(1);
          end
        end
        S_DONE: state_q <= S_IDLE;
        default: state_q <= S_IDLE;
      endcase
    end
  end

  assign busy = busy_q;
  assign done = done_q;
  assign eq   = eq_q;
  assign gt   = gt_q;
  assign lt   = lt_q;

endmodule

// File: doc/serial_magnitude_comparator.md
# serial_magnitude_comparator

Sequencing controller that compares two WIDTH-bit unsigned operands by driving a single 1-bit eq/gt/lt comparison stage over one operand bit per clock, MSB first. It accepts a start request, walks the bit index with a down-counter, accumulates the first decisive bit result, and reports a one-hot eq/gt/lt result with a one-cycle done pulse. It sits between a requesting control unit and the bit-level comparator datapath, trading latency for area on wide operands.

## Interface
- WIDTH, 8, operand width in bits; legal range 2..64
- clk  input  1  rising-edge clock
- rst  input  1  synchronous active-high reset
- start  input  1  request a compare; sampled only in IDLE
- a  input  WIDTH  operand A, unsigned; captured on the accepting edge
- b  input  WIDTH  operand B, unsigned; captured on the accepting edge
- busy  output  1  high while a compare is in progress (RUN state)
- done  output  1  one-cycle pulse when the result becomes valid
- eq  output  1  A == B; valid from done until the next accepted start
- gt  output  1  A > B; same validity as eq
- lt  output  1  A < B; same validity as eq

## Operation
- States: IDLE, RUN, DONE; reset state is IDLE.
- IDLE: if start=1, latch a and b into internal shift/hold registers, set bit index idx=WIDTH-1, clear eq/gt/lt to 0, go to RUN. If start=0, stay in IDLE and hold eq/gt/lt.
- RUN: each cycle, compare bits a_q[idx] and b_q[idx] with 1-bit semantics (eq = bits equal, gt = a_bit & ~b_bit, lt = ~a_bit & b_bit).
  - First unequal bit: record gt or lt in a sticky decided flag; later bits never override it.
  - idx decrements by 1 per RUN cycle. No wrap: after idx=0 is evaluated, go to DONE.
  - If no bit differed after idx=0, the result is eq=1.
- DONE: lasts exactly one cycle. done=1, busy=0, eq/gt/lt hold the final one-hot result. Unconditional return to IDLE.
- start is ignored in RUN and DONE, with no queueing. a and b changes after capture do not affect the compare in flight.
- After the first completed compare, exactly one of eq/gt/lt is 1 in every state until the next accepted start. Before any compare, all three are 0.
- Reset values: busy=0, done=0, eq=0, gt=0, lt=0, idx=0, state=IDLE, operand registers=0.
- rst=1 in any state, including mid-RUN, aborts the compare and returns to reset values on that edge. There is no done pulse for an aborted compare. rst has priority over start.

## Timing
- Edge T0: start=1 sampled in IDLE. busy=1 from T0.
- Edges T1..Tn each evaluate one bit, MSB at T1.
- Full sweep: n=WIDTH. State is DONE after edge T(WIDTH), so done=1 and results are valid in the cycle following T(WIDTH). Latency is WIDTH edges from accept to done.
- busy falls on the same edge that done rises.
- The earliest next accept is at the edge after DONE. Back-to-back throughput is one compare per WIDTH+2 cycles.

## Configuration
- SERIAL_CMP_EARLY_EXIT_EN
  - Defined: RUN goes to DONE on the edge that evaluates the first unequal bit. At MSB index i, done is visible after edge T(WIDTH-i). For equal operands, latency is unchanged at WIDTH.
  - Undefined: RUN always sweeps all WIDTH bits and latency is fixed at WIDTH. Results are identical in both builds.

## Test plan
- Reset, then idle 5 cycles: busy/done/eq/gt/lt all 0. Assert rst mid-RUN: all outputs return to 0, no done pulse.
- WIDTH=8, a=8'hA5, b=8'hA5 -> done exactly 8 edges after accept, eq=1, gt=0, lt=0, held until next start.
- a=8'h80, b=8'h7F -> gt=1. With SERIAL_CMP_EARLY_EXIT_EN, done after 1 edge; without it, after 8 edges.
- a=8'h12, b=8'h13 -> lt=1, done after 8 edges in both builds. Change a and b during RUN: result unchanged.
- Hold start=1 continuously: compares are accepted only in IDLE, one per 10 cycles. Each done is a single-cycle pulse, and eq/gt/lt clear to 0 on each accept.
- Random 1000 operand pairs in both builds: eq/gt/lt match a==b, a>b, a<b, and are one-hot at every done.
